data_memory_arbiter: RTL and testbench

Shares the single-port, byte-addressed data memory between two requesters: the pipeline Memory stage (core port) and the debug/program-loader port (dbg port). Grants at most one access per cycle and drives the memory's write-enable, control, address and write-data inputs. Routes the one-cycle-latency synchronous read data back to the requester that issued the read. Core has priority, but starvation and lock-length limits bound how long the dbg port can wait or hold the memory.

---
 rtl/data_memory_arbiter.sv | 165 ++++++++++++++++
 tb/tb_data_memory_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_arbiter
// Brief    : Core/debug arbiter for the shared single-port data memory.
// Revision : 1.0
// ============================================================================
module data_memory_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int LOCK_MAX     = 16
) (
    input  logic        CLK,
    input  logic        RST,

    input  logic        CORE_Req,
    input  logic        CORE_W_En,
    input  logic [2:0]  CORE_Control,
    input  logic [31:0] CORE_Addr,
    input  logic [31:0] CORE_W_Data,
    output logic        CORE_Gnt,
    output logic        CORE_Stall,
    output logic        CORE_R_Valid,
    output logic [31:0] CORE_R_Data,

    input  logic        DBG_Req,
    input  logic        DBG_Lock,
    input  logic        DBG_W_En,
    input  logic [2:0]  DBG_Control,
    input  logic [31:0] DBG_Addr,
    input  logic [31:0] DBG_W_Data,
    output logic        DBG_Gnt,
    output logic        DBG_R_Valid,
    output logic [31:0] DBG_R_Data,

    output logic        MEM_W_En,
    output logic [2:0]  MEM_Control,
    output logic [31:0] MEM_Addr,
    output logic [31:0] MEM_W_Data,
    input  logic [31:0] MEM_R_Data
);

    localparam logic [2:0] MEM_NONE = 3'b000;

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int LW = $clog2(LOCK_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIMIT);
    localparam logic [LW-1:0] LOCK_TOP   = LW'(LOCK_MAX);

    typedef enum logic [0:0] {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_nxt;
    logic [LW-1:0] lock_cnt;
    logic [LW-1:0] lock_nxt;
    logic          post_release;
    logic          post_release_nxt;
    logic          rsp_valid;
    logic          rsp_dbg;
    logic          core_gnt;
    logic          dbg_gnt;
    logic          starved;

    // Grant decision: purely combinational from current state and counters.
    always_comb begin
        core_gnt = 1'b0;
        dbg_gnt  = 1'b0;
        starved  = (starve_cnt == STARVE_TOP) && !post_release;
        if (state == ST_LOCKED) begin
            dbg_gnt = DBG_Req;
        end else if (DBG_Req && (starved || !CORE_Req)) begin
            dbg_gnt = 1'b1;
        end else begin
            core_gnt = CORE_Req;
        end
    end

    always_comb begin
        MEM_W_En    = 1'b0;
        MEM_Control = MEM_NONE;
        MEM_Addr    = 32'h0;
        MEM_W_Data  = 32'h0;
        if (core_gnt) begin
            MEM_W_En    = CORE_W_En;
            MEM_Control = CORE_Control;
            MEM_Addr    = CORE_Addr;
            MEM_W_Data  = CORE_W_Data;
        end else if (dbg_gnt) begin
            MEM_W_En    = DBG_W_En;
            MEM_Control = DBG_Control;
            MEM_Addr    = DBG_Addr;
            MEM_W_Data  = DBG_W_Data;
        end
    end

    always_comb begin
        state_nxt        = state;
        lock_nxt         = lock_cnt;
        post_release_nxt = 1'b0;
        starve_nxt       = '0;
        case (state)
            ST_OPEN: begin
                // Re-locking is suppressed for the single cycle after a forced release.
                if (dbg_gnt && DBG_Lock && !post_release) begin
                    state_nxt = ST_LOCKED;
                    lock_nxt  = LW'(1);
                end
            end
            ST_LOCKED: begin
                if (DBG_Lock && (lock_cnt < LOCK_TOP)) begin
                    lock_nxt = lock_cnt + LW'(1);
                end else begin
                    state_nxt        = ST_OPEN;
                    lock_nxt         = '0;
                    post_release_nxt = (lock_cnt == LOCK_TOP);
                end
            end
            default: begin
                state_nxt = ST_OPEN;
                lock_nxt  = '0;
            end
        endcase
        if (DBG_Req && !dbg_gnt) begin
            starve_nxt = (starve_cnt == STARVE_TOP) ? starve_cnt : starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= ST_OPEN;
            lock_cnt     <= '0;
            starve_cnt   <= '0;
            post_release <= 1'b0;
        end else begin
            state        <= state_nxt;
            lock_cnt     <= lock_nxt;
            starve_cnt   <= starve_nxt;
            post_release <= post_release_nxt;
        end
    end

    // Read-return tracking: memory data arrives one cycle after the grant.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rsp_valid <= 1'b0;
            rsp_dbg   <= 1'b0;
        end else begin
            rsp_valid <= (core_gnt && !CORE_W_En) || (dbg_gnt && !DBG_W_En);
            rsp_dbg   <= dbg_gnt;
        end
    end

    assign CORE_Gnt     = core_gnt;
    assign DBG_Gnt      = dbg_gnt;
    assign CORE_Stall   = CORE_Req && !core_gnt;
    assign CORE_R_Valid = rsp_valid && !rsp_dbg;
    assign DBG_R_Valid  = rsp_valid && rsp_dbg;
    assign CORE_R_Data  = CORE_R_Valid ? MEM_R_Data : 32'h0;
    assign DBG_R_Data   = DBG_R_Valid  ? MEM_R_Data : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_arbiter
// Brief    : Directed bench for data_memory_arbiter with a byte memory model.
// Revision : 1.0
// ============================================================================
module tb_data_memory_arbiter;

    localparam logic [2:0] MEM_NONE = 3'b000;
    localparam logic [2:0] MEM_BYTE = 3'b001;
    localparam logic [2:0] MEM_HALF = 3'b010;
    localparam logic [2:0] MEM_WORD = 3'b011;
    localparam logic [2:0] MEM_BU   = 3'b100;
    localparam logic [2:0] MEM_HU   = 3'b101;

    logic        clk;
    logic        rst;
    logic        core_req, core_we;
    logic [2:0]  core_ctl;
    logic [31:0] core_addr, core_wdata;
    logic        core_gnt, core_stall, core_rvalid;
    logic [31:0] core_rdata;
    logic        dbg_req, dbg_lock, dbg_we;
    logic [2:0]  dbg_ctl;
    logic [31:0] dbg_addr, dbg_wdata;
    logic        dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        mem_we;
    logic [2:0]  mem_ctl;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    data_memory_arbiter #(.STARVE_LIMIT(4), .LOCK_MAX(16)) dut (
        .CLK(clk), .RST(rst),
        .CORE_Req(core_req), .CORE_W_En(core_we), .CORE_Control(core_ctl),
        .CORE_Addr(core_addr), .CORE_W_Data(core_wdata), .CORE_Gnt(core_gnt),
        .CORE_Stall(core_stall), .CORE_R_Valid(core_rvalid), .CORE_R_Data(core_rdata),
        .DBG_Req(dbg_req), .DBG_Lock(dbg_lock), .DBG_W_En(dbg_we), .DBG_Control(dbg_ctl),
        .DBG_Addr(dbg_addr), .DBG_W_Data(dbg_wdata), .DBG_Gnt(dbg_gnt),
        .DBG_R_Valid(dbg_rvalid), .DBG_R_Data(dbg_rdata),
        .MEM_W_En(mem_we), .MEM_Control(mem_ctl), .MEM_Addr(mem_addr),
        .MEM_W_Data(mem_wdata), .MEM_R_Data(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Little-endian byte memory, 256 bytes, registered read.
    logic [7:0] mem [0:255];

    function automatic logic [31:0] rd(input logic [2:0] c, input logic [7:0] a);
        logic [7:0] a1, a2, a3;
        a1 = a + 8'd1;
        a2 = a + 8'd2;
        a3 = a + 8'd3;
        case (c)
            MEM_BYTE: rd = {{24{mem[a][7]}}, mem[a]};
            MEM_BU:   rd = {24'h0, mem[a]};
            MEM_HALF: rd = {{16{mem[a1][7]}}, mem[a1], mem[a]};
            MEM_HU:   rd = {16'h0, mem[a1], mem[a]};
            MEM_WORD: rd = {mem[a3], mem[a2], mem[a1], mem[a]};
            default:  rd = 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        mem_rdata <= rd(mem_ctl, mem_addr[7:0]);
        if (mem_we) begin
            case (mem_ctl)
                MEM_BYTE, MEM_BU: mem[mem_addr[7:0]] = mem_wdata[7:0];
                MEM_HALF, MEM_HU: begin
                    mem[mem_addr[7:0]]         = mem_wdata[7:0];
                    mem[mem_addr[7:0] + 8'd1]  = mem_wdata[15:8];
                end
                MEM_WORD: begin
                    mem[mem_addr[7:0]]         = mem_wdata[7:0];
                    mem[mem_addr[7:0] + 8'd1]  = mem_wdata[15:8];
                    mem[mem_addr[7:0] + 8'd2]  = mem_wdata[23:16];
                    mem[mem_addr[7:0] + 8'd3]  = mem_wdata[31:24];
                end
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        core_req = 1'b0;
        core_we  = 1'b0;
        dbg_req  = 1'b0;
        dbg_lock = 1'b0;
        dbg_we   = 1'b0;
    endtask

    task automatic core_load(input logic [2:0] c, input logic [31:0] a);
        core_req  = 1'b1;
        core_we   = 1'b0;
        core_ctl  = c;
        core_addr = a;
    endtask

    task automatic dbg_access(input logic we, input logic lk, input logic [2:0] c,
                              input logic [31:0] a, input logic [31:0] d);
        dbg_req   = 1'b1;
        dbg_we    = we;
        dbg_lock  = lk;
        dbg_ctl   = c;
        dbg_addr  = a;
        dbg_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h44; mem[8'h11] = 8'h33; mem[8'h12] = 8'h22; mem[8'h13] = 8'h11;
        mem[8'h20] = 8'hAB;
        rst = 1'b1;
        idle();
        core_ctl = MEM_NONE; core_addr = 32'h0; core_wdata = 32'h0;
        dbg_ctl = MEM_NONE; dbg_addr = 32'h0; dbg_wdata = 32'h0;

        // Reset state
        @(negedge clk);
        check("rst_core_gnt", {31'h0, core_gnt}, 32'd0);
        check("rst_dbg_gnt", {31'h0, dbg_gnt}, 32'd0);
        check("rst_core_rv", {31'h0, core_rvalid}, 32'd0);
        check("rst_mem_ctl", {29'h0, mem_ctl}, {29'h0, MEM_NONE});
        next_cycle();
        rst = 1'b0;

        // Core-only load
        core_load(MEM_WORD, 32'h10);
        @(negedge clk);
        check("t1_core_gnt", {31'h0, core_gnt}, 32'd1);
        check("t1_stall", {31'h0, core_stall}, 32'd0);
        check("t1_mem_addr", mem_addr, 32'h10);
        check("t1_mem_ctl", {29'h0, mem_ctl}, {29'h0, MEM_WORD});
        next_cycle();
        idle();
        @(negedge clk);
        check("t1_core_rv", {31'h0, core_rvalid}, 32'd1);
        check("t1_core_rd", core_rdata, 32'h11223344);
        check("t1_dbg_rv", {31'h0, dbg_rvalid}, 32'd0);
        check("t1_idle_addr", mem_addr, 32'h0);
        check("t1_idle_ctl", {29'h0, mem_ctl}, {29'h0, MEM_NONE});
        next_cycle();
        @(negedge clk);
        check("t1_core_rv_one", {31'h0, core_rvalid}, 32'd0);
        next_cycle();

        // Contention and starvation
        core_load(MEM_WORD, 32'h10);
        dbg_access(1'b0, 1'b0, MEM_BU, 32'h20, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("t2_core_gnt_%0d", i), {31'h0, core_gnt}, (i == 4 || i == 9) ? 32'd0 : 32'd1);
            check($sformatf("t2_dbg_gnt_%0d", i), {31'h0, dbg_gnt}, (i == 4 || i == 9) ? 32'd1 : 32'd0);
            check($sformatf("t2_stall_%0d", i), {31'h0, core_stall}, (i == 4 || i == 9) ? 32'd1 : 32'd0);
            if (i == 4) check("t2_mem_addr", mem_addr, 32'h20);
            if (i == 5) begin
                check("t2_dbg_rv", {31'h0, dbg_rvalid}, 32'd1);
                check("t2_dbg_rd", dbg_rdata, 32'h000000AB);
                check("t2_core_rd0", core_rdata, 32'h0);
            end
            if (i == 6) check("t2_core_rv", {31'h0, core_rvalid}, 32'd1);
            next_cycle();
        end
        idle();
        next_cycle();

        // Lock: three byte stores while the core waits
        for (int j = 0; j < 3; j++) begin
            dbg_access(1'b1, 1'b1, MEM_BYTE, 32'h30 + j, 32'hA1 + j);
            @(negedge clk);
            check($sformatf("t3_dbg_gnt_%0d", j), {31'h0, dbg_gnt}, 32'd1);
            check($sformatf("t3_core_gnt_%0d", j), {31'h0, core_gnt}, 32'd0);
            check($sformatf("t3_mem_we_%0d", j), {31'h0, mem_we}, 32'd1);
            check($sformatf("t3_mem_wd_%0d", j), mem_wdata, 32'hA1 + j);
            if (j > 0) begin
                check($sformatf("t3_stall_%0d", j), {31'h0, core_stall}, 32'd1);
                check($sformatf("t3_dbg_rv_%0d", j), {31'h0, dbg_rvalid}, 32'd0);
            end
            next_cycle();
            core_load(MEM_WORD, 32'h10);
        end
        dbg_req = 1'b0; dbg_lock = 1'b0; dbg_we = 1'b0;
        @(negedge clk);
        check("t3_exit_core_gnt", {31'h0, core_gnt}, 32'd0);
        check("t3_exit_stall", {31'h0, core_stall}, 32'd1);
        next_cycle();
        @(negedge clk);
        check("t3_after_core_gnt", {31'h0, core_gnt}, 32'd1);
        next_cycle();
        idle();
        dbg_access(1'b0, 1'b0, MEM_WORD, 32'h30, 32'h0);
        @(negedge clk);
        check("t3_rb_gnt", {31'h0, dbg_gnt}, 32'd1);
        check("t3_core_rv", {31'h0, core_rvalid}, 32'd1);
        next_cycle();
        idle();
        @(negedge clk);
        check("t3_rb_rv", {31'h0, dbg_rvalid}, 32'd1);
        check("t3_rb_data", dbg_rdata, 32'h00A3A2A1);
        next_cycle();

        // Forced release after LOCK_MAX locked cycles
        dbg_access(1'b0, 1'b1, MEM_BU, 32'h20, 32'h0);
        @(negedge clk);
        check("t4_lock_gnt", {31'h0, dbg_gnt}, 32'd1);
        next_cycle();
        core_load(MEM_WORD, 32'h10);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check($sformatf("t4_core_gnt_%0d", k), {31'h0, core_gnt}, 32'd0);
            check($sformatf("t4_dbg_gnt_%0d", k), {31'h0, dbg_gnt}, 32'd1);
            next_cycle();
        end
        @(negedge clk);
        check("t4_rel_core_gnt", {31'h0, core_gnt}, 32'd1);
        check("t4_rel_dbg_gnt", {31'h0, dbg_gnt}, 32'd0);
        next_cycle();
        core_req = 1'b0;
        @(negedge clk);
        check("t4_relock_gnt", {31'h0, dbg_gnt}, 32'd1);
        next_cycle();
        core_req = 1'b1;
        @(negedge clk);
        check("t4_relocked_core", {31'h0, core_gnt}, 32'd0);
        check("t4_relocked_dbg", {31'h0, dbg_gnt}, 32'd1);
        check("t4_relocked_stall", {31'h0, core_stall}, 32'd1);
        next_cycle();
        idle();
        next_cycle();
        next_cycle();

        // Interleaved core/dbg loads of the same byte
        core_load(MEM_BYTE, 32'h20);
        @(negedge clk);
        check("t5_core_gnt", {31'h0, core_gnt}, 32'd1);
        next_cycle();
        core_req = 1'b0;
        dbg_access(1'b0, 1'b0, MEM_BU, 32'h20, 32'h0);
        @(negedge clk);
        check("t5_dbg_gnt", {31'h0, dbg_gnt}, 32'd1);
        check("t5_core_rv", {31'h0, core_rvalid}, 32'd1);
        check("t5_core_rd", core_rdata, 32'hFFFFFFAB);
        check("t5_dbg_rv0", {31'h0, dbg_rvalid}, 32'd0);
        check("t5_dbg_rd0", dbg_rdata, 32'h0);
        next_cycle();
        idle();
        @(negedge clk);
        check("t5_dbg_rv", {31'h0, dbg_rvalid}, 32'd1);
        check("t5_dbg_rd", dbg_rdata, 32'h000000AB);
        check("t5_core_rv0", {31'h0, core_rvalid}, 32'd0);
        check("t5_core_rd0", core_rdata, 32'h0);
        next_cycle();
        @(negedge clk);
        check("t5_dbg_rv_one", {31'h0, dbg_rvalid}, 32'd0);
        next_cycle();

        // Reset mid-read with dbg at the starvation limit
        core_load(MEM_WORD, 32'h10);
        dbg_access(1'b0, 1'b0, MEM_BU, 32'h20, 32'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("t6_core_gnt_%0d", c), {31'h0, core_gnt}, 32'd1);
            next_cycle();
        end
        rst = 1'b1;
        #1;
        check("t6_rst_core_rv", {31'h0, core_rvalid}, 32'd0);
        check("t6_rst_core_rd", core_rdata, 32'h0);
        check("t6_rst_core_gnt", {31'h0, core_gnt}, 32'd1);
        check("t6_rst_dbg_gnt", {31'h0, dbg_gnt}, 32'd0);
        idle();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("t6_post_core_rv", {31'h0, core_rvalid}, 32'd0);
        check("t6_post_dbg_rv", {31'h0, dbg_rvalid}, 32'd0);
        next_cycle();
        @(negedge clk);
        check("t6_post2_core_rv", {31'h0, core_rvalid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
